// File: rtl/rvc_asap_cr_mem_pkg.sv
// Shared definitions for the CR_MEM control-register region: address map,
// register-set layouts and the byte-lane merge used by the store path.
package rvc_asap_cr_mem_pkg;

    localparam logic [31:0] CR_MEM_REGION_FLOOR = 32'h0000_7000;
    localparam logic [31:0] CR_MEM_REGION_ROOF  = 32'h0000_7FFF;

    localparam logic [31:0] CR_SEG7_0   = 32'h0000_7000;
    localparam logic [31:0] CR_SEG7_5   = 32'h0000_7014;
    localparam logic [31:0] CR_LED      = 32'h0000_7018;
    localparam logic [31:0] CR_BUTTON_0 = 32'h0000_701C;
    localparam logic [31:0] CR_BUTTON_1 = 32'h0000_7020;
    localparam logic [31:0] CR_SWITCH   = 32'h0000_7024;
    localparam logic [31:0] CR_CURSOR_H = 32'h0000_7028;
    localparam logic [31:0] CR_CURSOR_V = 32'h0000_702C;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int CR_RO_W                 = 12;

    typedef struct packed {
        logic [5:0][7:0] seg7;
        logic [9:0]      led;
        logic [31:0]     cursor_h;
        logic [31:0]     cursor_v;
    } t_cr_rw;

    // Bit order matches the {Button_0, Button_1, Switch} debouncer bank.
    typedef struct packed {
        logic       button_0;
        logic       button_1;
        logic [9:0] switch_v;
    } t_cr_ro;

    function automatic logic [31:0] cr_byte_merge(input logic [31:0] old_v,
                                                  input logic [31:0] wdata,
                                                  input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) r[8*n +: 8] = wdata[8*n +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rvc_asap_cr_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw input.
module rvc_asap_cr_debounce #(
    parameter int cycles = 16
) (
    input  logic Clock,
    input  logic Rst,
    input  logic raw,
    output logic clean
);
    localparam int CNT_W = (cycles > 1) ? $clog2(cycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cycles - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            // Any disagreement that reverts before the last count restarts it.
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign clean = deb_q;

endmodule

// File: rtl/rvc_asap_cr_mem.sv
// CR_MEM stage: decodes loads/stores to the control registers, holds the RW
// set driving displays/LEDs/cursor, and returns read data one cycle later.
module rvc_asap_cr_mem
    import rvc_asap_cr_mem_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] CrAddress,
    input  logic        CrWrEn,
    input  logic        CrRdEn,
    input  logic [3:0]  CrByteEn,
    input  logic [31:0] CrWrData,
    output logic [31:0] CrRdData,
    input  logic        Button_0,
    input  logic        Button_1,
    input  logic [9:0]  Switch,
    output logic [7:0]  SEG7_0,
    output logic [7:0]  SEG7_1,
    output logic [7:0]  SEG7_2,
    output logic [7:0]  SEG7_3,
    output logic [7:0]  SEG7_4,
    output logic [7:0]  SEG7_5,
    output logic [9:0]  LED,
    output logic [31:0] CursorH,
    output logic [31:0] CursorV
);
    t_cr_rw              rw_q, rw_d;
    t_cr_ro              ro;
    logic [31:0]         rd_data_q, rd_data_d;
    logic [31:0]         word_addr;
    logic                hit;
    logic [2:0]          seg_idx;
    logic [CR_RO_W-1:0]  raw_in;
    logic [CR_RO_W-1:0]  clean;

    assign raw_in = {Button_0, Button_1, Switch};

    for (genvar i = 0; i < CR_RO_W; i++) begin : g_deb
        rvc_asap_cr_debounce #(.cycles(DEBOUNCE_CYCLES)) u_deb (
            .Clock (Clock),
            .Rst   (Rst),
            .raw   (raw_in[i]),
            .clean (clean[i])
        );
    end

    assign ro = clean;

    assign hit       = (CrAddress >= CR_MEM_REGION_FLOOR) && (CrAddress <= CR_MEM_REGION_ROOF);
    assign word_addr = {CrAddress[31:2], 2'b00};
    assign seg_idx   = word_addr[4:2];

    // Read value is sampled from rw_q, so a same-cycle write never leaks into it.
    always_comb begin
        rw_d      = rw_q;
        rd_data_d = '0;
        if (hit) begin
            if (word_addr >= CR_SEG7_0 && word_addr <= CR_SEG7_5) begin
                rd_data_d = 32'(rw_q.seg7[seg_idx]);
                if (CrWrEn)
                    rw_d.seg7[seg_idx] = 8'(cr_byte_merge(32'(rw_q.seg7[seg_idx]), CrWrData, CrByteEn));
            end else begin
                case (word_addr)
                    CR_LED: begin
                        rd_data_d = 32'(rw_q.led);
                        if (CrWrEn)
                            rw_d.led = 10'(cr_byte_merge(32'(rw_q.led), CrWrData, CrByteEn));
                    end
                    CR_BUTTON_0: rd_data_d = 32'(ro.button_0);
                    CR_BUTTON_1: rd_data_d = 32'(ro.button_1);
                    CR_SWITCH:   rd_data_d = 32'(ro.switch_v);
                    CR_CURSOR_H: begin
                        rd_data_d = rw_q.cursor_h;
                        if (CrWrEn)
                            rw_d.cursor_h = cr_byte_merge(rw_q.cursor_h, CrWrData, CrByteEn);
                    end
                    CR_CURSOR_V: begin
                        rd_data_d = rw_q.cursor_v;
                        if (CrWrEn)
                            rw_d.cursor_v = cr_byte_merge(rw_q.cursor_v, CrWrData, CrByteEn);
                    end
                    default: rd_data_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            rw_q      <= '0;
            rd_data_q <= '0;
        end else begin
            rw_q <= rw_d;
            if (CrRdEn) rd_data_q <= rd_data_d;
        end
    end

    assign CrRdData = rd_data_q;
    assign SEG7_0   = rw_q.seg7[0];
    assign SEG7_1   = rw_q.seg7[1];
    assign SEG7_2   = rw_q.seg7[2];
    assign SEG7_3   = rw_q.seg7[3];
    assign SEG7_4   = rw_q.seg7[4];
    assign SEG7_5   = rw_q.seg7[5];
    assign LED      = rw_q.led;
    assign CursorH  = rw_q.cursor_h;
    assign CursorV  = rw_q.cursor_v;

endmodule

// File: tb/tb_rvc_asap_cr_mem.sv
// Scoreboard bench for rvc_asap_cr_mem with DEBOUNCE_CYCLES=4 and directed vectors.
module tb_rvc_asap_cr_mem;

    logic        Clock;
    logic        Rst;
    logic [31:0] CrAddress;
    logic        CrWrEn;
    logic        CrRdEn;
    logic [3:0]  CrByteEn;
    logic [31:0] CrWrData;
    logic [31:0] CrRdData;
    logic        Button_0;
    logic        Button_1;
    logic [9:0]  Switch;
    logic [7:0]  SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5;
    logic [9:0]  LED;
    logic [31:0] CursorH;
    logic [31:0] CursorV;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_exp[$];
    string       q_nm[$];
    logic        rd_seen;

    logic [7:0]  m_seg [6];
    logic [9:0]  m_led;
    logic [31:0] m_ch;
    logic [31:0] m_cv;

    rvc_asap_cr_mem #(.DEBOUNCE_CYCLES(4)) dut (
        .Clock     (Clock),
        .Rst       (Rst),
        .CrAddress (CrAddress),
        .CrWrEn    (CrWrEn),
        .CrRdEn    (CrRdEn),
        .CrByteEn  (CrByteEn),
        .CrWrData  (CrWrData),
        .CrRdData  (CrRdData),
        .Button_0  (Button_0),
        .Button_1  (Button_1),
        .Switch    (Switch),
        .SEG7_0    (SEG7_0),
        .SEG7_1    (SEG7_1),
        .SEG7_2    (SEG7_2),
        .SEG7_3    (SEG7_3),
        .SEG7_4    (SEG7_4),
        .SEG7_5    (SEG7_5),
        .LED       (LED),
        .CursorH   (CursorH),
        .CursorV   (CursorV)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge Clock) rd_seen <= CrRdEn;

    always @(negedge Clock) begin
        if (rd_seen === 1'b1) begin
            if (q_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow actual=%0h required=none", CrRdData);
            end else begin
                chk(q_nm.pop_front(), 128'(CrRdData), 128'(q_exp.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        CrAddress = a;
        CrWrData  = d;
        CrByteEn  = be;
        CrWrEn    = 1'b1;
        tick();
        CrWrEn    = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] e);
        CrAddress = a;
        CrRdEn    = 1'b1;
        q_nm.push_back(nm);
        q_exp.push_back(e);
        tick();
        CrRdEn    = 1'b0;
    endtask

    task automatic rdwr(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        CrAddress = a;
        CrWrData  = d;
        CrByteEn  = 4'hF;
        CrWrEn    = 1'b1;
        CrRdEn    = 1'b1;
        q_nm.push_back(nm);
        q_exp.push_back(e);
        tick();
        CrWrEn    = 1'b0;
        CrRdEn    = 1'b0;
    endtask

    task automatic check_outs(input string nm);
        chk(nm, 128'({SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5, LED, CursorH, CursorV}),
                128'({m_seg[0], m_seg[1], m_seg[2], m_seg[3], m_seg[4], m_seg[5], m_led, m_ch, m_cv}));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 6; i++) m_seg[i] = 8'h00;
        m_led = '0;
        m_ch  = '0;
        m_cv  = '0;
    endtask

    logic [31:0] offs [12];

    initial begin
        offs = '{32'h7000, 32'h7004, 32'h7008, 32'h700C, 32'h7010, 32'h7014,
                 32'h7018, 32'h701C, 32'h7020, 32'h7024, 32'h7028, 32'h702C};
        Rst = 1'b1;
        CrAddress = '0; CrWrEn = 1'b0; CrRdEn = 1'b0; CrByteEn = '0; CrWrData = '0;
        Button_0 = 1'b0; Button_1 = 1'b0; Switch = '0;
        model_clear();
        repeat (3) @(posedge Clock);
        #1 Rst = 1'b0;

        check_outs("reset_outs");
        for (int i = 0; i < 12; i++) rd($sformatf("reset_rd_%0h", offs[i]), offs[i], 32'h0);

        wr(32'h7000, 32'h1234_5678, 4'b1111); m_seg[0] = 8'h78;
        wr(32'h7004, 32'h0000_AB00, 4'b0010); m_seg[1] = 8'h00;
        wr(32'h7008, 32'h0000_00C3, 4'b0000); m_seg[2] = 8'h00;
        wr(32'h700C, 32'hDEAD_BE77, 4'b0001); m_seg[3] = 8'h77;
        wr(32'h7014, 32'h0000_005A, 4'b0001); m_seg[5] = 8'h5A;
        wr(32'h7028, 32'hA5A5_1234, 4'b0011); m_ch = 32'h0000_1234;
        wr(32'h7018, 32'hFFFF_FFFF, 4'b1111); m_led = 10'h3FF;
        wr(32'h702C, 32'h0000_0005, 4'b1111); m_cv = 32'h5;
        check_outs("after_writes");

        rd("seg0",    32'h7000, 32'h78);
        rd("seg1",    32'h7004, 32'h0);
        rd("seg3",    32'h700C, 32'h77);
        rd("seg5",    32'h7014, 32'h5A);
        rd("led",     32'h7018, 32'h3FF);
        rd("cur_h",   32'h7028, 32'h1234);
        rd("cur_h_b", 32'h702B, 32'h1234);

        wr(32'h7028, 32'hBEEF_0000, 4'b1100); m_ch = 32'hBEEF_1234;
        rd("cur_h_hi", 32'h7028, 32'hBEEF_1234);

        rdwr("rdw_old", 32'h702C, 32'h9, 32'h5); m_cv = 32'h9;
        rd("rdw_new", 32'h702C, 32'h9);

        wr(32'h7024, 32'hFFFF_FFFF, 4'hF);
        wr(32'h7030, 32'hFFFF_FFFF, 4'hF);
        wr(32'h6FFC, 32'hFFFF_FFFF, 4'hF);
        wr(32'h8000, 32'hFFFF_FFFF, 4'hF);
        wr(32'h701C, 32'hFFFF_FFFF, 4'hF);
        wr(32'h7FFC, 32'hFFFF_FFFF, 4'hF);
        check_outs("ro_protect");
        rd("sw_ro",   32'h7024, 32'h0);
        rd("unmap",   32'h7030, 32'h0);
        rd("below",   32'h6FFC, 32'h0);
        rd("above",   32'h8000, 32'h0);
        rd("roof",    32'h7FFC, 32'h0);
        rd("b0_ro",   32'h701C, 32'h0);

        Button_0 = 1'b1;
        for (int j = 0; j < 9; j++) rd($sformatf("deb_b0_%0d", j), 32'h701C, (j <= 5) ? 32'h0 : 32'h1);

        for (int j = 0; j < 12; j++) begin
            Switch = (j < 3) ? 10'h008 : 10'h000;
            rd($sformatf("glitch_%0d", j), 32'h7024, 32'h0);
        end

        Switch = 10'h2A9;
        repeat (7) tick();
        rd("sw_clean", 32'h7024, 32'h2A9);

        tick();
        Button_1 = 1'b1;
        repeat (4) tick();
        CrAddress = 32'h7028; CrWrData = 32'hFFFF_FFFF; CrByteEn = 4'hF; CrWrEn = 1'b1;
        Rst = 1'b1;
        tick();
        CrWrEn = 1'b0;
        tick();
        Rst = 1'b0;
        model_clear();
        check_outs("rst_mid");
        for (int j = 0; j < 9; j++) rd($sformatf("redeb_b1_%0d", j), 32'h7020, (j <= 5) ? 32'h0 : 32'h1);
        rd("b0_after", 32'h701C, 32'h1);
        rd("sw_after", 32'h7024, 32'h2A9);
        rd("seg0_rst", 32'h7000, 32'h0);
        rd("led_rst",  32'h7018, 32'h0);
        rd("curh_rst", 32'h7028, 32'h0);
        rd("curv_rst", 32'h702C, 32'h0);

        repeat (3) tick();
        chk("sb_empty", 128'(q_exp.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
